muldiv: RTL and testbench
=========================

MULDIV -- requirements
Module: muldiv

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  input  1  sole clock, rising-edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request a new operation; sampled at the rising edge.
REQ-005 Port: op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 Port: A  input  32  multiplicand / dividend (rs).
REQ-007 Port: B  input  32  multiplier / divisor (rt).
REQ-008 Port: hi_we  input  1  MTHI write strobe.
REQ-009 Port: lo_we  input  1  MTLO write strobe.
REQ-010 Port: wdata  input  32  data for MTHI/MTLO.
REQ-011 Port: busy  output  1  operation in progress; the pipeline stalls MFHI/MFLO/MULT/DIV/MTHI/MTLO while it is high.
REQ-012 Port: done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-013 Port: hi  output  32  HI register (registered output).
REQ-014 Port: lo  output  32  LO register (registered output).

Function
REQ-015 FSM states SHALL be IDLE, MUL, DIV and FIN; all outputs SHALL be registered.
REQ-016 In IDLE with start=1, the block SHALL capture op, A and B at edge k, then enter MUL (op[1]=0) or DIV (op[1]=1) with busy=1 after edge k.
REQ-017 Operand changes after edge k SHALL have no effect on the result.
REQ-018 MUL/DIV SHALL iterate one bit per cycle, radix-2, for exactly 32 cycles on an internal 5-bit iteration counter.
REQ-019 The block SHALL then spend one FIN cycle applying the sign fixup.
REQ-020 At edge k+33, hi/lo SHALL update, busy SHALL fall and done SHALL rise; done SHALL fall at edge k+34.
REQ-021 A following start SHALL be accepted at edge k+33 at the earliest, i.e. back-to-back operations are allowed.
REQ-022 Signed ops SHALL iterate on absolute values and then negate the results as follows.
REQ-023 Product sign fixup: negate the product when the operand signs differ.
REQ-024 Quotient sign fixup: negate the quotient when the operand signs differ.
REQ-025 Remainder sign fixup: the remainder SHALL take the sign of the dividend.
REQ-026 Multiply SHALL write the 64-bit product as HI = [63:32] and LO = [31:0].
REQ-027 Divide SHALL write LO = quotient and HI = remainder.
REQ-028 Divide by zero (any op DIV/DIVU, B=0) SHALL take the full 33 cycles and produce LO=0xFFFFFFFF, HI=A (dividend unmodified).
REQ-029 Signed overflow DIV 0x80000000 / 0xFFFFFFFF SHALL produce LO=0x80000000, HI=0x00000000.
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 hi_we/lo_we while busy=1 SHALL be ignored.
REQ-032 In IDLE, hi_we/lo_we SHALL write wdata to HI/LO at the edge.
REQ-033 If both hi_we and lo_we are set in IDLE, both HI and LO SHALL be written.
REQ-034 When start and hi_we/lo_we coincide in IDLE, start SHALL win and the write SHALL be dropped.
REQ-035 hi/lo SHALL hold their previous values throughout busy and change only at the FIN edge or on an accepted write.
REQ-036 done SHALL never assert without a preceding accepted start.

Reset
REQ-037 rst_n=0 SHALL immediately, regardless of clk, force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, and clear captured operands.
REQ-038 Reset mid-operation SHALL abort the operation with no done pulse and no HI/LO update.
REQ-039 After rst_n rises, the first start SHALL be accepted on the next rising edge.

Verification
REQ-040 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> busy high 33 cycles; HI=0xFFFFFFFE, LO=0x00000001; done high exactly 1 cycle.
REQ-041 MULT A=0xFFFFFFFD(-3) B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; then DIV A=0xFFFFFFF9(-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-042 DIVU A=7 B=0 -> LO=0xFFFFFFFF, HI=0x00000007; DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-043 Busy-window rejection: during an op, pulse start with a different op and hi_we with wdata=0x12345678 -> first result unchanged; a single done; HI not 0x12345678.
REQ-044 Reset abort: assert rst_n=0 asynchronously (mid-cycle) at iteration 10 of a MULTU -> hi=lo=0 and busy=0 before the next edge; no done; a fresh MULTU 3*4 afterwards -> LO=12, HI=0.
REQ-045 IDLE writes: lo_we with wdata=0xA5A5A5A5 -> lo=0xA5A5A5A5 next cycle, hi unchanged; start and hi_we in the same cycle -> op runs and the write is dropped.

Source files
------------

// File: rtl/muldiv.sv
// ---------------------------------------------------------------------------
// MuLDiv: iterative 32-bit multiply / divide unit with HI/LO result registers.
//
// The unit takes one operation at a time, iterates radix-2 (one bit per cycle)
// for 32 cycles on absolute values, and spends one final cycle applying the
// sign fixup and writing HI/LO. MTHI/MTLO-style writes are accepted only while
// the unit is idle.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request a new operation (sampled at the rising edge)
//   op     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B   - multiplicand/dividend and multiplier/divisor
//   hi_we  - write wdata into HI while idle
//   lo_we  - write wdata into LO while idle
//   wdata  - data for HI/LO writes
//   busy   - operation in progress
//   done   - one-cycle pulse when HI/LO take a new result
//   hi, lo - HI and LO registers
// ---------------------------------------------------------------------------
module muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    logic [1:0]         state;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [4:0]         cnt;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   work;

    logic               accept;
    logic               in_neg_a;
    logic               in_neg_b;
    logic [WIDTH-1:0]   in_a_abs;
    logic [WIDTH-1:0]   in_b_abs;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Datapath helpers. acc:work forms one double-width shift register:
    // for multiply acc holds the partial product high half and work the
    // multiplier being shifted out; for divide acc is the partial remainder
    // and work shifts the dividend out while quotient bits shift in.
    // A start is also taken in FIN so operations can run back-to-back.
    always_comb begin
        accept      = start && ((state == IDLE) || (state == FIN));

        in_neg_a    = ~op[0] & A[WIDTH-1];
        in_neg_b    = ~op[0] & B[WIDTH-1];
        in_a_abs    = in_neg_a ? -A : A;
        in_b_abs    = in_neg_b ? -B : B;

        neg_a       = ~op_q[0] & a_q[WIDTH-1];
        neg_b       = ~op_q[0] & b_q[WIDTH-1];
        a_abs       = neg_a ? -a_q : a_q;
        b_abs       = neg_b ? -b_q : b_q;

        mul_sum     = work[0] ? (acc + {1'b0, a_abs}) : acc;

        div_shift   = {acc[WIDTH-1:0], work[WIDTH-1]};
        div_diff    = {1'b0, div_shift} - {2'b00, b_abs};

        product     = {acc[WIDTH-1:0], work};
        product_fix = (neg_a ^ neg_b) ? -product : product;
        quot_fix    = (neg_a ^ neg_b) ? -work : work;
        rem_fix     = neg_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end

    // Control FSM, iteration datapath and HI/LO registers. A start
    // overrides any simultaneous HI/LO write; divide by zero bypasses the
    // sign fixup so the dividend lands in HI untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt   <= '0;
            acc   <= '0;
            work  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!start) begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                MUL: begin
                    acc  <= {1'b0, mul_sum[WIDTH:1]};
                    work <= {mul_sum[0], work[WIDTH-1:1]};
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIN;
                end
                DIV: begin
                    if (!div_diff[WIDTH+1]) begin
                        acc  <= div_diff[WIDTH:0];
                        work <= {work[WIDTH-2:0], 1'b1};
                    end else begin
                        acc  <= div_shift;
                        work <= {work[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIN;
                end
                FIN: begin
                    if (op_q[1]) begin
                        if (b_q == '0) begin
                            hi <= a_q;
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end
                    end else begin
                        hi <= product_fix[2*WIDTH-1:WIDTH];
                        lo <= product_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                state <= op[1] ? DIV : MUL;
                busy  <= 1'b1;
                op_q  <= op;
                a_q   <= A;
                b_q   <= B;
                cnt   <= '0;
                acc   <= '0;
                work  <= op[1] ? in_a_abs : in_b_abs;
            end
        end
    end

endmodule

// File: tb/tb_muldiv.sv
// ---------------------------------------------------------------------------
// tb_muldiv: self-checking bench for muldiv. Expected HI/LO pairs come from
// a plain-arithmetic reference model and are queued when an operation is
// issued; a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          numChecks = 0;
    int          numErrors = 0;
    logic [63:0] expQ[$];
    logic [31:0] hiModel;
    logic [31:0] loModel;

    muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Reference model: returns {HI, LO} using ordinary 64-bit arithmetic.
    function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        refModel = 64'd0;
        case (o)
            2'b00: refModel = 64'(sa * sb);
            2'b01: refModel = ua * ub;
            2'b10: begin
                if (b == 32'd0) refModel = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) refModel = {32'h0, 32'h80000000};
                else begin
                    q = 64'(sa / sb);
                    r = 64'(sa % sb);
                    refModel = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) refModel = {a, 32'hFFFFFFFF};
                else refModel = {a % b, a / b};
            end
        endcase
    endfunction

    // Single comparison point: counts every check and reports misses.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [63:0] exp;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (expQ.size() == 0) begin
                numChecks++;
                numErrors++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no pending operation");
            end else begin
                exp = expQ.pop_front();
                checkOutput("result_hilo", {hi, lo}, exp);
            end
        end
    end

    // Idle HI/LO write, issued at a falling edge while not busy.
    task automatic idleWrite(input logic h, input logic l, input logic [31:0] d);
        hi_we = h;
        lo_we = l;
        wdata = d;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (h) hiModel = d;
        if (l) loModel = d;
        checkOutput("idle_write", {hi, lo}, {hiModel, loModel});
    endtask

    // Issue one operation, optionally with a coincident (dropped) write or
    // with start/hi_we pulses inside the busy window, then wait for it.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input bit writeWithStart, input bit injectBusy);
        logic [63:0] exp;
        int          cycles;
        exp = refModel(o, a, b);
        expQ.push_back(exp);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        if (writeWithStart) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            wdata = 32'hDEADBEEF;
        end
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        A     = $urandom;
        B     = $urandom;
        op    = 2'($urandom_range(3, 0));
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            checkOutput("hold_hilo", {hi, lo}, {hiModel, loModel});
            if (injectBusy && cycles == 5) begin
                start = 1'b1;
                op    = ~o;
                hi_we = 1'b1;
                wdata = 32'h12345678;
            end else if (injectBusy && cycles == 6) begin
                start = 1'b0;
                hi_we = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput("busy_cycles", 64'(cycles), 64'd33);
        hiModel = exp[63:32];
        loModel = exp[31:0];
        @(negedge clk);
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        A     = 32'd0;
        B     = 32'd0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'd0;
        hiModel = 32'd0;
        loModel = 32'd0;

        #12;
        checkOutput("reset_hilo", {hi, lo}, 64'd0);
        checkOutput("reset_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle writes: LO alone, HI alone, then both.
        idleWrite(1'b0, 1'b1, 32'hA5A5A5A5);
        idleWrite(1'b1, 1'b0, 32'h0BADF00D);
        idleWrite(1'b1, 1'b1, 32'h13579BDF);

        // Directed operations with their known results.
        applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        checkOutput("multu_max", {hi, lo}, {32'hFFFFFFFE, 32'h00000001});
        applyStimulus(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0);
        checkOutput("mult_neg", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFF1});
        applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        checkOutput("div_neg", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        applyStimulus(2'b11, 32'd7, 32'd0, 1'b0, 1'b0);
        checkOutput("divu_zero", {hi, lo}, {32'h00000007, 32'hFFFFFFFF});
        applyStimulus(2'b10, 32'hFFFFFFF9, 32'd0, 1'b0, 1'b0);
        checkOutput("div_zero_signed", {hi, lo}, {32'hFFFFFFF9, 32'hFFFFFFFF});
        applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        checkOutput("div_overflow", {hi, lo}, {32'h00000000, 32'h80000000});

        // Start and hi_we pulsed inside the busy window must be ignored.
        applyStimulus(2'b01, 32'h00010001, 32'h00030003, 1'b0, 1'b1);
        checkOutput("busy_reject", {hi, lo}, {32'h00000003, 32'h00060003});
        repeat (40) @(negedge clk);
        checkOutput("busy_reject_idle", {hi, lo}, {hiModel, loModel});

        // Start together with HI/LO writes: the operation wins.
        applyStimulus(2'b01, 32'd2, 32'd3, 1'b1, 1'b0);
        checkOutput("start_wins", {hi, lo}, {32'd0, 32'd6});

        // Randomized operations with occasional corner operands.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(3, 0));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(7, 0))
                0: rb = 32'd0;
                1: ra = 32'h80000000;
                2: rb = 32'hFFFFFFFF;
                3: rb = 32'($urandom_range(15, 1));
                default: ;
            endcase
            applyStimulus(ro, ra, rb, 1'b0, 1'b0);
        end

        // Reset in the middle of a MULTU: nonzero HI/LO first.
        applyStimulus(2'b01, 32'h00012345, 32'h00006789, 1'b0, 1'b0);
        start = 1'b1;
        op    = 2'b01;
        A     = 32'hFFFFFFFF;
        B     = 32'h0000FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_hilo", {hi, lo}, 64'd0);
        checkOutput("abort_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hiModel = 32'd0;
        loModel = 32'd0;
        repeat (40) @(negedge clk);
        checkOutput("abort_idle_hilo", {hi, lo}, 64'd0);
        applyStimulus(2'b01, 32'd3, 32'd4, 1'b0, 1'b0);
        checkOutput("after_abort", {hi, lo}, {32'd0, 32'd12});

        repeat (5) @(negedge clk);
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
        $finish;
    end

endmodule
